apb_ral_apb_master: RTL and testbench
=====================================

# apb_ral_apb_master

APB initiator that converts a simple valid/ready command stream into single APB transfers (SETUP then ACCESS) and returns each result on a valid/ready response stream. It sits between the RAL frontdoor and the APB slave memory/register model as the requester end of the APB link. It allows one outstanding transfer at a time and supports wait states, slave errors and an optional access timeout.

## Interface
- ADDR_W, 32, address width of cmd_addr/paddr
- DATA_W, 32, data width of wdata/rdata paths
- TIMEOUT, 16, ACCESS cycles with pready low before abort (used only with timeout feature)
- pclk  in  1  clock
- presetn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high at pclk edge
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when both high
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_err  out  1  pslverr or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- paddr  out  ADDR_W  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error

## Operation
- All outputs registered; reset value 0 for every output except cmd_ready = 1 (state IDLE).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid: latch write/addr/wdata to pwrite/paddr/pwdata, psel=1, penable=0, cmd_ready=0 -> SETUP.
- SETUP: exactly one cycle; penable=1 -> ACCESS.
- ACCESS: hold paddr/pwrite/pwdata/psel/penable stable while pready=0. On pready=1: capture rsp_rdata = prdata for reads, 0 for writes; rsp_err = pslverr; rsp_timeout=0; psel=penable=0; rsp_valid=1 -> RESP.
- RESP: hold rsp_* stable until rsp_ready=1; then rsp_valid=0, cmd_ready=1 -> IDLE. Commands are not accepted in RESP.
- paddr/pwrite/pwdata keep last value while idle; only psel/penable return to 0.
- pslverr sampled only on the pready=1 ACCESS cycle; ignored otherwise.
- Reset asserted mid-transfer: immediate return to IDLE, psel/penable/rsp_valid drop to 0 asynchronously, in-flight command discarded, no response produced.

## Timing
- Command accepted at edge T -> psel=1 after T, penable=1 after T+1.
- Zero-wait slave: pready sampled high at edge T+2 -> rsp_valid=1 after T+2 (3 cycles command-to-response).
- Each pready-low ACCESS cycle adds one cycle.
- Minimum command-to-command spacing: 4 cycles with rsp_ready held high (IDLE, SETUP, ACCESS, RESP).
- cmd_ready and rsp_valid are never high in the same cycle.

## Configuration
- APB_RAL_MASTER_TIMEOUT_EN defined: counter clears on SETUP entry, increments each ACCESS cycle with pready=0; when it reaches TIMEOUT with pready still 0, abort: psel=penable=0, rsp_rdata=0, rsp_err=1, rsp_timeout=1, go to RESP. pready=1 on the abort cycle wins (normal completion).
- Not defined: no counter; ACCESS waits indefinitely; rsp_timeout tied to 0; TIMEOUT unused.

## Test plan
- Write addr 0x1000 data 0x0000_0005, pready=1 -> psel 1 cycle before penable, pwdata=0x5 held through ACCESS, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read 0x0010 after writing 0xCAFE_F00D there, zero-wait slave -> rsp_rdata=0xCAFE_F00D, rsp_err=0.
- Read 0x1004 with pready low 3 ACCESS cycles -> paddr/psel/penable stable 4 ACCESS cycles, rsp_valid 6 cycles after accept.
- Write with pslverr=1 on pready cycle; rsp_ready held low 5 cycles -> rsp_err=1, rsp_valid and data held 5 cycles, cmd_ready stays 0 until handshake.
- With APB_RAL_MASTER_TIMEOUT_EN, TIMEOUT=16, pready stuck low -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0; without macro -> no response after 100 cycles.
- presetn low during ACCESS of a read -> psel/penable/rsp_valid 0 immediately, cmd_ready=1 after release, next read completes normally.

Source files
------------

// File: rtl/apb_ral_apb_master.sv
// apb_ral_apb_master: valid/ready command stream to single APB transfers, one outstanding.
// Optional ACCESS timeout enabled by defining APB_RAL_MASTER_TIMEOUT_EN.
module apb_ral_apb_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state, state_n;
  logic cmd_ready_n, psel_n, penable_n, pwrite_n, rsp_valid_n, rsp_err_n;
  logic [ADDR_W-1:0] paddr_n;
  logic [DATA_W-1:0] pwdata_n, rsp_rdata_n;
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end
`ifdef APB_RAL_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic rsp_timeout_n, expired;
  assign expired = cnt == CW'(TIMEOUT - 1);
`else
  assign rsp_timeout = 1'b0;
`endif
  always_comb begin
    state_n     = state;
    cmd_ready_n = cmd_ready;
    psel_n      = psel;
    penable_n   = penable;
    pwrite_n    = pwrite;
    paddr_n     = paddr;
    pwdata_n    = pwdata;
    rsp_valid_n = rsp_valid;
    rsp_rdata_n = rsp_rdata;
    rsp_err_n   = rsp_err;
`ifdef APB_RAL_MASTER_TIMEOUT_EN
    cnt_n         = cnt;
    rsp_timeout_n = rsp_timeout;
`endif
    case (state)
      IDLE: if (cmd_valid) begin
        state_n     = SETUP;
        cmd_ready_n = 1'b0;
        psel_n      = 1'b1;
        pwrite_n    = cmd_write;
        paddr_n     = cmd_addr;
        pwdata_n    = cmd_wdata;
`ifdef APB_RAL_MASTER_TIMEOUT_EN
        cnt_n       = '0;
`endif
      end
      SETUP: begin
        state_n   = ACCESS;
        penable_n = 1'b1;
      end
      ACCESS: if (pready) begin
        state_n     = RESP;
        psel_n      = 1'b0;
        penable_n   = 1'b0;
        rsp_valid_n = 1'b1;
        rsp_rdata_n = pwrite ? '0 : prdata;
        rsp_err_n   = pslverr;
`ifdef APB_RAL_MASTER_TIMEOUT_EN
        rsp_timeout_n = 1'b0;
      end else if (expired) begin
        state_n       = RESP;
        psel_n        = 1'b0;
        penable_n     = 1'b0;
        rsp_valid_n   = 1'b1;
        rsp_rdata_n   = '0;
        rsp_err_n     = 1'b1;
        rsp_timeout_n = 1'b1;
      end else begin
        cnt_n = cnt + 1'b1;
`endif
      end
      RESP: if (rsp_ready) begin
        state_n     = IDLE;
        rsp_valid_n = 1'b0;
        cmd_ready_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_RAL_MASTER_TIMEOUT_EN
      cnt         <= '0;
      rsp_timeout <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cmd_ready <= cmd_ready_n;
      psel      <= psel_n;
      penable   <= penable_n;
      pwrite    <= pwrite_n;
      paddr     <= paddr_n;
      pwdata    <= pwdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_err   <= rsp_err_n;
`ifdef APB_RAL_MASTER_TIMEOUT_EN
      cnt         <= cnt_n;
      rsp_timeout <= rsp_timeout_n;
`endif
    end
endmodule

// File: tb/tb_apb_ral_apb_master.sv
// tb_apb_ral_apb_master: directed bench with a transaction-level expectation model and APB slave memory.
module tb_apb_ral_apb_master;
  localparam int TO = 16;
  logic pclk = 0, presetn = 0;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [31:0] cmd_addr = 0, cmd_wdata = 0;
  logic rsp_valid, rsp_ready = 1, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, paddr, pwdata;
  logic psel, penable, pwrite;
  logic [31:0] prdata = 0;
  logic pready = 0, pslverr = 0;
  int checks = 0, failures = 0, cyc = 0;
  int cfg_wait = 0, acc = 0;
  logic cfg_err = 0, stuck = 0;
  logic [31:0] mem [logic [31:0]];
  logic m_cr = 1, m_psel = 0, m_pen = 0, m_pw = 0, m_rv = 0, m_re = 0, m_rt = 0;
  logic [31:0] m_pa = 0, m_pd = 0, m_rd = 0;
  int m_wait = 0;
  apb_ral_apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );
  always #5 pclk = ~pclk;
  initial forever begin
    @(posedge pclk);
    cyc++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  // Expected outputs follow the handshake/APB phase rules one transfer at a time.
  initial forever begin
    @(posedge pclk or negedge presetn);
    if (!presetn) begin
      m_cr = 1; m_psel = 0; m_pen = 0; m_pw = 0; m_pa = 0; m_pd = 0;
      m_rv = 0; m_rd = 0; m_re = 0; m_rt = 0;
    end else if (m_cr && cmd_valid) begin
      m_cr = 0; m_psel = 1; m_pw = cmd_write; m_pa = cmd_addr; m_pd = cmd_wdata;
    end else if (m_psel && !m_pen) begin
      m_pen = 1; m_wait = 0;
    end else if (m_pen && pready) begin
      m_psel = 0; m_pen = 0; m_rv = 1; m_rd = m_pw ? 32'h0 : prdata; m_re = pslverr; m_rt = 0;
    end else if (m_pen) begin
      m_wait++;
`ifdef APB_RAL_MASTER_TIMEOUT_EN
      if (m_wait == TO) begin
        m_psel = 0; m_pen = 0; m_rv = 1; m_rd = 0; m_re = 1; m_rt = 1;
      end
`endif
    end else if (m_rv && rsp_ready) begin
      m_rv = 0; m_cr = 1;
    end
  end
  initial forever begin
    @(negedge pclk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, paddr, psel, penable, pwrite, pwdata} !==
        {m_cr, m_rv, m_rd, m_re, m_rt, m_pa, m_psel, m_pen, m_pw, m_pd}) begin
      failures++;
      $display("FAIL cycle%0d actual cr=%b rv=%b rd=%h err=%b to=%b pa=%h sel=%b en=%b w=%b wd=%h required cr=%b rv=%b rd=%h err=%b to=%b pa=%h sel=%b en=%b w=%b wd=%h",
               cyc, cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, paddr, psel, penable, pwrite, pwdata,
               m_cr, m_rv, m_rd, m_re, m_rt, m_pa, m_psel, m_pen, m_pw, m_pd);
    end
  end
  // Slave: counts ACCESS cycles, asserts pslverr on wait cycles to show it is ignored there.
  initial forever begin
    @(negedge pclk);
    if (psel && penable) begin
      pready = !stuck && acc >= cfg_wait;
      pslverr = pready ? cfg_err : 1'b1;
      prdata = pready ? (mem.exists(paddr) ? mem[paddr] : 32'h0) : 32'hDEAD_BEEF;
      if (pready && pwrite && !cfg_err) mem[paddr] = pwdata;
      acc++;
    end else begin
      acc = 0; pready = 0; pslverr = 0; prdata = 32'h0BAD_0BAD;
    end
  end
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input int waits,
                      input logic err, input int hold, output int t, output int lat,
                      output logic [31:0] rd, output logic e, output logic to);
    int n;
    cfg_wait = waits; cfg_err = err; rsp_ready = (hold == 0);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge pclk); n++; end
    t = cyc;
    @(negedge pclk);
    cmd_valid = 0;
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge pclk); n++; end
    chk("rsp_seen", rsp_valid, 1);
    lat = cyc - t; rd = rsp_rdata; e = rsp_err; to = rsp_timeout;
    for (int i = 1; i < hold; i++) begin
      @(negedge pclk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_err", rsp_err, err);
    end
    rsp_ready = 1;
    @(negedge pclk);
  endtask
  initial begin
    int t1, t2, lat, seen;
    logic [31:0] rd;
    logic e, to;
    repeat (2) @(negedge pclk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_psel", psel, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    presetn = 1;
    @(negedge pclk);
    xact(1, 32'h1000, 32'h5, 0, 0, 0, t1, lat, rd, e, to);
    chk("wr_lat", lat, 3);
    chk("wr_err", e, 0);
    chk("wr_rdata", rd, 0);
    xact(1, 32'h10, 32'hCAFE_F00D, 0, 0, 0, t1, lat, rd, e, to);
    xact(0, 32'h10, 32'h0, 0, 0, 0, t2, lat, rd, e, to);
    chk("spacing", t2 - t1, 4);
    chk("rd_data", rd, 32'hCAFE_F00D);
    chk("rd_err", e, 0);
    xact(1, 32'h1004, 32'h1234_5678, 0, 0, 0, t1, lat, rd, e, to);
    xact(0, 32'h1004, 32'h0, 3, 0, 0, t1, lat, rd, e, to);
    chk("wait_lat", lat, 6);
    chk("wait_data", rd, 32'h1234_5678);
    xact(1, 32'h2000, 32'hA5A5, 0, 1, 5, t1, lat, rd, e, to);
    chk("slverr_err", e, 1);
    chk("slverr_rdata", rd, 0);
    chk("slverr_to", to, 0);
    stuck = 1;
`ifdef APB_RAL_MASTER_TIMEOUT_EN
    xact(0, 32'h10, 32'h0, 0, 0, 0, t1, lat, rd, e, to);
    chk("to_lat", lat, TO + 2);
    chk("to_flag", to, 1);
    chk("to_err", e, 1);
    chk("to_rdata", rd, 0);
    stuck = 0;
`else
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h3000;
    @(negedge pclk);
    cmd_valid = 0;
    seen = 0;
    repeat (100) begin
      @(negedge pclk);
      if (rsp_valid) seen = 1;
    end
    chk("no_to_rsp", seen, 0);
    chk("no_to_penable", penable, 1);
    presetn = 0;
    @(negedge pclk);
    stuck = 0;
    presetn = 1;
    @(negedge pclk);
`endif
    cfg_wait = 10;
    cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h10;
    @(negedge pclk);
    cmd_valid = 0;
    @(negedge pclk);
    chk("mid_in_access", penable, 1);
    #2 presetn = 0;
    #1;
    chk("mid_psel", psel, 0);
    chk("mid_penable", penable, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    @(negedge pclk);
    presetn = 1;
    @(negedge pclk);
    chk("mid_cmd_ready", cmd_ready, 1);
    xact(0, 32'h10, 32'h0, 0, 0, 0, t1, lat, rd, e, to);
    chk("post_rst_data", rd, 32'hCAFE_F00D);
    chk("post_rst_lat", lat, 3);
    repeat (2) @(negedge pclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
